wb_fifo_device: RTL and testbench

- Pipelined Wishbone (B4) device end of the team's `wishbone` interface.
- Sinks controller write data into a synchronous FIFO and presents it downstream as a first-word-fall-through valid/ready stream.
- Sits behind any `wishbone.controller` driver, e.g. a UART TX path or a register-push bridge.
- The interface carries no read data, so reads are answered with an error.

---
 rtl/wb_fifo_device_if.sv | 35 +++
 rtl/wb_fifo_device.sv | 102 ++++++++++
 tb/tb_wb_fifo_device.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_fifo_device_if.sv
// Pipelined Wishbone (B4) write-sink bus bundle between a controller and wb_fifo_device.
//
// Signals:
//   cyc    controller -> device  bus cycle in progress
//   stb    controller -> device  request strobe
//   we     controller -> device  write enable
//   dat    controller -> device  write data, DAT_WIDTH bits
//   ack    device -> controller  normal termination
//   err    device -> controller  error termination (reads are not supported)
//   rty    device -> controller  retry termination
//   stall  device -> controller  pipeline stall
interface wb_fifo_device_if #(
  parameter int unsigned DAT_WIDTH = 8
) ();

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [DAT_WIDTH-1:0] dat;
  logic                 ack;
  logic                 err;
  logic                 rty;
  logic                 stall;

  modport master (
    output cyc, stb, we, dat,
    input  ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, dat,
    output ack, err, rty, stall
  );

endinterface

// File: rtl/wb_fifo_device.sv
// Wishbone (B4 pipelined) write sink feeding a synchronous FIFO, drained through a
// first-word-fall-through valid/ready stream. Reads are answered with err.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   bus          wb_fifo_device_if slave side (cyc/stb/we/dat in, ack/err/rty/stall out)
//   out_valid_o  FIFO non-empty
//   out_data_o   head of FIFO (don't-care while out_valid_o is low)
//   out_ready_i  downstream consumes the head when high together with out_valid_o
//   level_o      current occupancy, 0..DEPTH
module wb_fifo_device #(
  parameter int unsigned DAT_WIDTH     = 8,
  parameter int unsigned DEPTH         = 4,
  parameter bit          RETRY_ON_FULL = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  wb_fifo_device_if.slave              bus,
  output logic                         out_valid_o,
  output logic [DAT_WIDTH-1:0]         out_data_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DAT_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          rty_q, rty_d;

  logic full;
  logic stall;
  logic accept;
  logic push;
  logic pop;

  // Full-check uses the registered count only: a pop in the same cycle does not free a slot.
  assign full   = (count_q == CW'(DEPTH));
  assign stall  = rst_i | (RETRY_ON_FULL ? 1'b0 : full);
  assign accept = bus.cyc & bus.stb & ~stall;
  assign push   = accept & bus.we & ~full;
  assign pop    = (count_q != '0) & out_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ack_d = push;
    err_d = accept & ~bus.we;
    // Only reachable in retry mode; otherwise a full FIFO stalls the request.
    rty_d = accept & bus.we & full;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rty_q    <= rty_d;
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.dat;
    end
  end

  // Responses vanish if the controller abandons the cycle, and a response still pending
  // while reset is asserted is dropped rather than delivered.
  assign bus.ack   = ack_q & bus.cyc & ~rst_i;
  assign bus.err   = err_q & bus.cyc & ~rst_i;
  assign bus.rty   = RETRY_ON_FULL ? (rty_q & bus.cyc & ~rst_i) : 1'b0;
  assign bus.stall = stall;

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem[rd_ptr_q];
  assign level_o     = count_q;

endmodule

// File: tb/tb_wb_fifo_device.sv
module tb_wb_fifo_device;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_fifo_device_if #(.DAT_WIDTH(8)) bus0 ();
  wb_fifo_device_if #(.DAT_WIDTH(8)) bus1 ();

  logic       rdy0, rdy1, valid0, valid1;
  logic [7:0] data0, data1;
  logic [2:0] level0, level1;

  wb_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .RETRY_ON_FULL(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .out_valid_o(valid0), .out_data_o(data0),
    .out_ready_i(rdy0), .level_o(level0)
  );

  wb_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .RETRY_ON_FULL(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .out_valid_o(valid1), .out_data_o(data1),
    .out_ready_i(rdy1), .level_o(level1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt0 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp0, exp1;

  // Scoreboards: every transfer on the output streams is checked against the expected order.
  always @(negedge clk) begin
    if (valid0 === 1'b1 && rdy0 === 1'b1) begin
      n_tests++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL pop0_unexpected: got %0h, expected no output", data0);
      end else begin
        exp0 = q0.pop_front();
        if (data0 !== exp0) begin
          n_fail++;
          $display("FAIL pop0_data: got %0h, expected %0h", data0, exp0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid1 === 1'b1 && rdy1 === 1'b1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL pop1_unexpected: got %0h, expected no output", data1);
      end else begin
        exp1 = q1.pop_front();
        if (data1 !== exp1) begin
          n_fail++;
          $display("FAIL pop1_data: got %0h, expected %0h", data1, exp1);
        end
      end
    end
  end

  always @(negedge clk) if (bus0.ack === 1'b1) ack_cnt0++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain0(output int n);
    n = 0;
    rdy0 = 1'b1;
    @(negedge clk);
    while (valid0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rdy0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, expected 0", bus0.ack); end
    n_tests++; if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", bus0.err); end
    n_tests++; if (bus1.rty !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b, expected 0", bus1.rty); end
    n_tests++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid0); end
    n_tests++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d, expected 0", level0); end
    n_tests++; if (bus0.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall0: got %b, expected 1", bus0.stall); end
    n_tests++; if (bus1.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall1: got %b, expected 1", bus1.stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus0.stall !== 1'b0) begin n_fail++; $display("FAIL reset_release_stall: got %b, expected 0", bus0.stall); end
    n_tests++; if (level1 !== 3'd0) begin n_fail++; $display("FAIL reset_level1: got %0d, expected 0", level1); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    rdy0 = 1'b0;
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1; bus0.dat = 8'hA5;
    q0.push_back(8'hA5);
    @(negedge clk);
    n_tests++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: got %b, expected 0", bus0.ack); end
    @(posedge clk); #1;
    bus0.stb = 1'b0;
    @(negedge clk);
    n_tests++; if (bus0.ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b, expected 1", bus0.ack); end
    n_tests++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, expected 1", valid0); end
    n_tests++; if (data0 !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %0h, expected a5", data0); end
    n_tests++; if (level0 !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d, expected 1", level0); end
    @(posedge clk); #1;
    rdy0 = 1'b1;
    @(negedge clk);
    n_tests++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b, expected 0", bus0.ack); end
    @(posedge clk); #1;
    rdy0 = 1'b0; bus0.cyc = 1'b0;
    @(negedge clk);
    n_tests++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d, expected 0", level0); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_stall();
    int a0, n;
    a0 = ack_cnt0;
    rdy0 = 1'b0;
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus0.dat = 8'(i);
      q0.push_back(8'(i));
      @(negedge clk);
      n_tests++; if (bus0.stall !== 1'b0) begin n_fail++; $display("FAIL fill_no_stall%0d: got %b, expected 0", i, bus0.stall); end
      @(posedge clk); #1;
    end
    bus0.dat = 8'h05;
    q0.push_back(8'h05);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (bus0.stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall%0d: got %b, expected 1", k, bus0.stall); end
      n_tests++; if (level0 !== 3'd4) begin n_fail++; $display("FAIL fill_level%0d: got %0d, expected 4", k, level0); end
      n_tests++; if (bus0.rty !== 1'b0) begin n_fail++; $display("FAIL fill_rty%0d: got %b, expected 0", k, bus0.rty); end
      @(posedge clk); #1;
    end
    n_tests++; if (ack_cnt0 - a0 !== 4) begin n_fail++; $display("FAIL fill_acks: got %0d, expected 4", ack_cnt0 - a0); end
    rdy0 = 1'b1;
    for (int i = 5; i <= 6; i++) begin
      if (i == 6) begin
        bus0.dat = 8'h06;
        q0.push_back(8'h06);
      end
      n = 0;
      @(negedge clk);
      while (bus0.stall && n < 10) begin
        @(negedge clk);
        n++;
      end
      n_tests++; if (n >= 10) begin n_fail++; $display("FAIL fill_release%0d: still stalled after %0d cycles, expected accept", i, n); end
      @(posedge clk); #1;
    end
    bus0.stb = 1'b0;
    drain0(n);
    bus0.cyc = 1'b0;
    n_tests++; if (n >= 20) begin n_fail++; $display("FAIL fill_drain: %0d cycles, expected < 20", n); end
    n_tests++; if (ack_cnt0 - a0 !== 6) begin n_fail++; $display("FAIL fill_total_acks: got %0d, expected 6", ack_cnt0 - a0); end
    n_tests++; if (q0.size() !== 0) begin n_fail++; $display("FAIL fill_lost: %0d left, expected 0", q0.size()); end
  endtask

  task automatic test_read();
    int n;
    rdy0 = 1'b0;
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1; bus0.dat = 8'h3C;
    q0.push_back(8'h3C);
    @(posedge clk); #1;
    bus0.we = 1'b0;
    @(negedge clk);
    n_tests++; if (bus0.ack !== 1'b1) begin n_fail++; $display("FAIL read_prior_ack: got %b, expected 1", bus0.ack); end
    @(posedge clk); #1;
    bus0.stb = 1'b0;
    @(negedge clk);
    n_tests++; if (bus0.err !== 1'b1) begin n_fail++; $display("FAIL read_err: got %b, expected 1", bus0.err); end
    n_tests++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL read_ack: got %b, expected 0", bus0.ack); end
    n_tests++; if (level0 !== 3'd1) begin n_fail++; $display("FAIL read_level: got %0d, expected 1", level0); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL read_err_pulse: got %b, expected 0", bus0.err); end
    @(posedge clk); #1;
    bus0.cyc = 1'b0;
    drain0(n);
    n_tests++; if (q0.size() !== 0) begin n_fail++; $display("FAIL read_drain: %0d left, expected 0", q0.size()); end
  endtask

  task automatic test_retry();
    int n;
    rdy1 = 1'b0;
    bus1.cyc = 1'b1; bus1.stb = 1'b1; bus1.we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.dat = 8'h10 + 8'(i);
      q1.push_back(8'h10 + 8'(i));
      @(posedge clk); #1;
    end
    bus1.dat = 8'h77;
    @(negedge clk);
    n_tests++; if (bus1.stall !== 1'b0) begin n_fail++; $display("FAIL retry_stall: got %b, expected 0", bus1.stall); end
    n_tests++; if (level1 !== 3'd4) begin n_fail++; $display("FAIL retry_full_level: got %0d, expected 4", level1); end
    @(posedge clk); #1;
    bus1.stb = 1'b0;
    @(negedge clk);
    n_tests++; if (bus1.rty !== 1'b1) begin n_fail++; $display("FAIL retry_rty: got %b, expected 1", bus1.rty); end
    n_tests++; if (bus1.ack !== 1'b0) begin n_fail++; $display("FAIL retry_ack: got %b, expected 0", bus1.ack); end
    n_tests++; if (bus1.err !== 1'b0) begin n_fail++; $display("FAIL retry_err: got %b, expected 0", bus1.err); end
    n_tests++; if (level1 !== 3'd4) begin n_fail++; $display("FAIL retry_level: got %0d, expected 4", level1); end
    @(posedge clk); #1;
    bus1.cyc = 1'b0;
    rdy1 = 1'b1;
    n = 0;
    @(negedge clk);
    while (valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rdy1 = 1'b0;
    n_tests++; if (q1.size() !== 0 || n >= 20) begin n_fail++; $display("FAIL retry_drain: %0d left after %0d cycles, expected 0", q1.size(), n); end
  endtask

  task automatic test_stream_wrap();
    int a0, n, max_level, stalls;
    a0 = ack_cnt0; max_level = 0; stalls = 0;
    rdy0 = 1'b1;
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus0.dat = 8'hC0 + 8'(i);
      q0.push_back(8'hC0 + 8'(i));
      @(negedge clk);
      if (int'(level0) > max_level) max_level = int'(level0);
      if (bus0.stall) stalls++;
      @(posedge clk); #1;
    end
    bus0.stb = 1'b0;
    @(negedge clk);
    if (int'(level0) > max_level) max_level = int'(level0);
    @(posedge clk); #1;
    bus0.cyc = 1'b0;
    drain0(n);
    n_tests++; if (max_level > 1) begin n_fail++; $display("FAIL stream_level: max %0d, expected <= 1", max_level); end
    n_tests++; if (stalls !== 0) begin n_fail++; $display("FAIL stream_stall: got %0d stalls, expected 0", stalls); end
    n_tests++; if (ack_cnt0 - a0 !== 16) begin n_fail++; $display("FAIL stream_acks: got %0d, expected 16", ack_cnt0 - a0); end
    n_tests++; if (q0.size() !== 0) begin n_fail++; $display("FAIL stream_lost: %0d left, expected 0", q0.size()); end
  endtask

  task automatic test_reset_drop();
    rdy0 = 1'b0;
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1; bus0.dat = 8'h99;
    @(posedge clk); #1;
    bus0.stb = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL rstdrop_ack: got %b, expected 0", bus0.ack); end
    n_tests++; if (bus0.stall !== 1'b1) begin n_fail++; $display("FAIL rstdrop_stall: got %b, expected 1", bus0.stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL rstdrop_level: got %0d, expected 0", level0); end
    n_tests++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rstdrop_valid: got %b, expected 0", valid0); end
    n_tests++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL rstdrop_late_ack: got %b, expected 0", bus0.ack); end
    @(posedge clk); #1;
    bus0.cyc = 1'b0;
  endtask

  task automatic test_cyc_drop();
    int n;
    rdy0 = 1'b0;
    bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1; bus0.dat = 8'h5A;
    q0.push_back(8'h5A);
    @(posedge clk); #1;
    bus0.cyc = 1'b0; bus0.stb = 1'b0;
    @(negedge clk);
    n_tests++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL cycdrop_ack: got %b, expected 0", bus0.ack); end
    n_tests++; if (level0 !== 3'd1) begin n_fail++; $display("FAIL cycdrop_level: got %0d, expected 1", level0); end
    n_tests++; if (data0 !== 8'h5A) begin n_fail++; $display("FAIL cycdrop_data: got %0h, expected 5a", data0); end
    @(posedge clk); #1;
    drain0(n);
    n_tests++; if (q0.size() !== 0) begin n_fail++; $display("FAIL cycdrop_lost: %0d left, expected 0", q0.size()); end
  endtask

  initial begin
    rst = 1'b1;
    rdy0 = 1'b0; rdy1 = 1'b0;
    bus0.cyc = 1'b0; bus0.stb = 1'b0; bus0.we = 1'b0; bus0.dat = 8'h00;
    bus1.cyc = 1'b0; bus1.stb = 1'b0; bus1.we = 1'b0; bus1.dat = 8'h00;
    test_reset();
    test_single_write();
    test_fill_stall();
    test_read();
    test_retry();
    test_stream_wrap();
    test_reset_drop();
    test_cyc_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
